// File: rtl/cpu6_pkg.sv
// Shared definitions for the CPU6 memory bus controller: state encoding,
// default wait limit and the data value returned by a timed-out read.
package cpu6_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } bus_state_t;

    localparam int         WAIT_LIMIT_DEFAULT = 15;
    localparam logic [7:0] TIMEOUT_RDATA      = 8'hFF;

endpackage

// File: rtl/mem_bus_ctrl.sv
// Single-transfer memory bus sequencer: IDLE -> SETUP -> STROBE -> HOLD.
// Every output is a register loaded from the next-state decode.
module mem_bus_ctrl
    import cpu6_pkg::*;
#(
    parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        err_clr,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        timeout_err,
    output logic [15:0] addressBus,
    output logic [7:0]  mem_dout,
    output logic        mem_doe,
    input  logic [7:0]  mem_din,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic        mem_ready
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    bus_state_t       r_state;
    bus_state_t       w_state_next;
    logic             w_timeout;
    logic             w_we_eff;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_we;
    logic             r_busy;
    logic             r_done;
    logic [7:0]       r_rdata;
    logic             r_timeout_err;
    logic [15:0]      r_addr_bus;
    logic [7:0]       r_mem_dout;
    logic             r_mem_doe;
    logic             r_mem_rd;
    logic             r_mem_wr;

    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE:   if (req) w_state_next = ST_SETUP;
            ST_SETUP:  w_state_next = ST_STROBE;
            ST_STROBE: begin
                // A ready sampled on the limit cycle still wins over the timeout.
                if (mem_ready) begin
                    w_state_next = ST_HOLD;
                end else if (r_wait_cnt == CNT_W'(WAIT_LIMIT - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Direction for the next cycle: the live input on accept, the latched one otherwise.
    assign w_we_eff = (r_state == ST_IDLE) ? we : r_we;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= '0;
            r_we          <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_rdata       <= 8'h00;
            r_timeout_err <= 1'b0;
            r_addr_bus    <= 16'h0000;
            r_mem_dout    <= 8'h00;
            r_mem_doe     <= 1'b0;
            r_mem_rd      <= 1'b0;
            r_mem_wr      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_busy    <= (w_state_next != ST_IDLE);
            r_done    <= (w_state_next == ST_HOLD);
            r_mem_rd  <= (w_state_next == ST_STROBE) && !w_we_eff;
            r_mem_wr  <= (w_state_next == ST_STROBE) && w_we_eff;
            r_mem_doe <= (w_state_next != ST_IDLE) && w_we_eff;

            if (r_state == ST_IDLE && req) begin
                r_we       <= we;
                r_addr_bus <= addr;
                if (we) r_mem_dout <= wdata;
            end

            if (r_state == ST_SETUP) begin
                r_wait_cnt <= '0;
            end else if (r_state == ST_STROBE && !mem_ready) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end

            if (r_state == ST_STROBE && !r_we) begin
                if (mem_ready)      r_rdata <= mem_din;
                else if (w_timeout) r_rdata <= TIMEOUT_RDATA;
            end

            if (w_timeout)    r_timeout_err <= 1'b1;
            else if (err_clr) r_timeout_err <= 1'b0;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign rdata       = r_rdata;
    assign timeout_err = r_timeout_err;
    assign addressBus  = r_addr_bus;
    assign mem_dout    = r_mem_dout;
    assign mem_doe     = r_mem_doe;
    assign mem_rd      = r_mem_rd;
    assign mem_wr      = r_mem_wr;

endmodule
